// File: rtl/load_access_unit_pkg.sv
// load_access_unit_pkg: load opcodes shared by the load unit and its lane extractor.
package load_access_unit_pkg;
   localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
   localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
   localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
   localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
   localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
   function automatic logic is_load(input logic [7:0] op);
      return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
   endfunction
endpackage

// File: rtl/load_access_unit_if.sv
// load_access_unit_if: request/grant/response data-memory port of the load unit.
interface load_access_unit_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   modport master (output mem_req, mem_addr, input mem_gnt, mem_rvalid, mem_rdata);
   modport slave (input mem_req, mem_addr, output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/load_extract.sv
// load_extract: little-endian lane select plus sign/zero extension of load data.
module load_extract
   import load_access_unit_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [7:0]  op,
   input  logic [1:0]  addr,
   output logic [31:0] result
);
   logic [7:0]  b;
   logic [15:0] h;
   always_comb begin
      b = rdata[{addr, 3'b000} +: 8];
      h = addr[1] ? rdata[31:16] : rdata[15:0];
      result = op == EXE_LB_OP  ? {{24{b[7]}}, b} :
               op == EXE_LBU_OP ? {24'b0, b} :
               op == EXE_LH_OP  ? {{16{h[15]}}, h} :
               op == EXE_LHU_OP ? {16'b0, h} : rdata;
   end
endmodule

// File: rtl/load_access_unit.sv
// load_access_unit: E-stage load sequencer with response timeout and flush drain.
// Define LOAD_MISALIGN_EXC_EN to raise adel/badvaddr on misaligned LH/LHU/LW.
module load_access_unit
   import load_access_unit_pkg::*;
#(
   parameter int RESP_TIMEOUT = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ld_valid,
   input  logic [7:0]                alucontrolE,
   input  logic [31:0]               addressE,
   input  logic                      flush,
   output logic                      ld_ready,
   output logic                      stall,
   load_access_unit_if.master        bus,
   output logic                      ld_done,
   output logic [31:0]               ld_result,
   output logic                      bus_err,
   output logic                      adel,
   output logic [31:0]               badvaddr
);
   typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} state_t;
   localparam int TW = $clog2(RESP_TIMEOUT + 1);
   state_t state, state_n;
   logic [TW-1:0] tcnt;
   logic [7:0] op_q;
   logic [1:0] lane_q;
   logic [31:0] addr_q, result_n;
   logic misalign, take, accept, expired, done_n, err_n;
`ifdef LOAD_MISALIGN_EXC_EN
   assign misalign = ((alucontrolE == EXE_LH_OP || alucontrolE == EXE_LHU_OP) && addressE[0]) ||
                     (alucontrolE == EXE_LW_OP && addressE[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif
   assign take = state == IDLE && ld_valid && !flush && is_load(alucontrolE);
   assign accept = take && !misalign;
   assign expired = tcnt == TW'(RESP_TIMEOUT - 1);
   assign ld_ready = state == IDLE;
   assign stall = state != IDLE;
   assign bus.mem_req = state == REQ;
   assign bus.mem_addr = addr_q;
   load_extract u_extract (.rdata(bus.mem_rdata), .op(op_q), .addr(lane_q), .result(result_n));
   // A response that races a flush in RESP is consumed here, so DRAIN never waits for a second one.
   always_comb begin
      state_n = state;
      done_n = 1'b0;
      err_n = 1'b0;
      case (state)
         IDLE:  state_n = accept ? REQ : IDLE;
         REQ:   state_n = flush ? (bus.mem_gnt ? DRAIN : IDLE) : (bus.mem_gnt ? RESP : REQ);
         RESP: begin
            if (bus.mem_rvalid) begin
               state_n = IDLE;
               done_n = !flush;
            end else if (flush) state_n = DRAIN;
            else if (expired) begin
               state_n = IDLE;
               err_n = 1'b1;
            end
         end
         DRAIN: state_n = (bus.mem_rvalid || expired) ? IDLE : DRAIN;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         tcnt <= '0;
         op_q <= '0;
         lane_q <= '0;
         addr_q <= '0;
         ld_done <= 1'b0;
         ld_result <= '0;
         bus_err <= 1'b0;
      end else begin
         state <= state_n;
         tcnt <= (state_n == state && (state == RESP || state == DRAIN)) ? tcnt + 1'b1 : '0;
         ld_done <= done_n;
         bus_err <= err_n;
         if (done_n) ld_result <= result_n;
         if (accept) begin
            op_q <= alucontrolE;
            lane_q <= addressE[1:0];
            addr_q <= {addressE[31:2], 2'b00};
         end
      end
   end
`ifdef LOAD_MISALIGN_EXC_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         adel <= 1'b0;
         badvaddr <= '0;
      end else begin
         adel <= take && misalign;
         if (take && misalign) badvaddr <= addressE;
      end
   end
`else
   assign adel = 1'b0;
   assign badvaddr = '0;
`endif
endmodule

// File: tb/tb_load_access_unit.sv
// tb_load_access_unit: directed vectors with hand-computed results for load_access_unit.
module tb_load_access_unit;
   import load_access_unit_pkg::*;
   logic clk = 0, rst = 1, ld_valid = 0, flush = 0;
   logic [7:0] alucontrolE = '0;
   logic [31:0] addressE = '0;
   logic ld_ready, stall, ld_done, bus_err, adel;
   logic [31:0] ld_result, badvaddr;
   logic [31:0] last_res = '0;
   int vectors = 0, errs = 0;
   load_access_unit_if bus ();
   load_access_unit #(.RESP_TIMEOUT(64)) dut (
      .clk(clk), .rst(rst), .ld_valid(ld_valid), .alucontrolE(alucontrolE), .addressE(addressE),
      .flush(flush), .ld_ready(ld_ready), .stall(stall), .bus(bus), .ld_done(ld_done),
      .ld_result(ld_result), .bus_err(bus_err), .adel(adel), .badvaddr(badvaddr)
   );
   always #5 clk = ~clk;
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h, want %h", tag, got, exp);
      end
   endtask
   task automatic issue(input logic [7:0] op, input logic [31:0] addr);
      ld_valid = 1;
      alucontrolE = op;
      addressE = addr;
      step;
      ld_valid = 0;
   endtask
   task automatic load(input string tag, input logic [7:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] expv, input int gnt_wait);
      int lat;
      issue(op, addr);
      lat = 1;
      chk({tag, "_req"}, bus.mem_req, 1);
      chk({tag, "_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
      for (int i = 0; i < gnt_wait; i++) begin
         bus.mem_rvalid = (i == 1);
         step;
         lat++;
         chk({tag, "_hold"}, {bus.mem_req, stall, ld_done}, 3'b110);
         chk({tag, "_hold_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
      end
      bus.mem_rvalid = 0;
      bus.mem_gnt = 1;
      step;
      lat++;
      bus.mem_gnt = 0;
      chk({tag, "_resp_nodone"}, ld_done, 0);
      bus.mem_rvalid = 1;
      bus.mem_rdata = data;
      step;
      lat++;
      bus.mem_rvalid = 0;
      chk({tag, "_done"}, ld_done, 1);
      chk({tag, "_result"}, ld_result, expv);
      chk({tag, "_latency"}, lat, 3 + gnt_wait);
      chk({tag, "_ready"}, ld_ready, 1);
      last_res = expv;
      step;
      chk({tag, "_done_pulse"}, ld_done, 0);
   endtask
   initial begin
      int n;
      bus.mem_gnt = 0;
      bus.mem_rvalid = 0;
      bus.mem_rdata = '0;
      step;
      step;
      chk("rst_ready", {ld_ready, stall, bus.mem_req, ld_done, bus_err, adel}, 6'b100000);
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_result", ld_result, 0);
      rst = 0;
      step;
      load("lb_1003", EXE_LB_OP, 32'h1003, 32'h80FF1234, 32'hFFFFFF80, 0);
      load("lbu_1001", EXE_LBU_OP, 32'h1001, 32'h80FF1234, 32'h00000012, 0);
      load("lb_1000", EXE_LB_OP, 32'h1000, 32'h80FF1234, 32'h00000034, 0);
      load("lbu_1002", EXE_LBU_OP, 32'h1002, 32'h80FF1234, 32'h000000FF, 0);
      load("lb_1002", EXE_LB_OP, 32'h1002, 32'h80FF1234, 32'hFFFFFFFF, 0);
      load("lh_1000", EXE_LH_OP, 32'h1000, 32'h80FF1234, 32'h00001234, 0);
      load("lh_1002", EXE_LH_OP, 32'h1002, 32'h80FF1234, 32'hFFFF80FF, 0);
      load("lhu_0002", EXE_LHU_OP, 32'h0002, 32'hBEEF0001, 32'h0000BEEF, 0);
      load("lh_0002", EXE_LH_OP, 32'h0002, 32'hBEEF0001, 32'hFFFFBEEF, 0);
      load("lw_0000", EXE_LW_OP, 32'h0000, 32'hBEEF0001, 32'hBEEF0001, 0);
      load("lw_gnt_wait", EXE_LW_OP, 32'h2004, 32'h12345678, 32'h12345678, 5);
      // non-load opcode and flush-vs-ld_valid are both ignored
      issue(8'h00, 32'h4000);
      chk("nonload_ignored", {ld_ready, bus.mem_req}, 2'b10);
      flush = 1;
      issue(EXE_LW_OP, 32'h4000);
      flush = 0;
      chk("flush_prio", {ld_ready, bus.mem_req}, 2'b10);
      // flush in REQ without grant
      issue(EXE_LW_OP, 32'h5000);
      flush = 1;
      step;
      flush = 0;
      chk("flush_req", {ld_ready, bus.mem_req}, 2'b10);
      // flush in REQ with same-cycle grant drains
      issue(EXE_LW_OP, 32'h5000);
      flush = 1;
      bus.mem_gnt = 1;
      step;
      flush = 0;
      bus.mem_gnt = 0;
      chk("flush_gnt_drain", {stall, bus.mem_req}, 2'b10);
      bus.mem_rvalid = 1;
      bus.mem_rdata = 32'h11111111;
      step;
      bus.mem_rvalid = 0;
      chk("drain1_exit", {ld_ready, ld_done}, 2'b10);
      chk("drain1_result", ld_result, last_res);
      // flush in RESP, rvalid two cycles later
      issue(EXE_LW_OP, 32'h3000);
      bus.mem_gnt = 1;
      step;
      bus.mem_gnt = 0;
      flush = 1;
      step;
      flush = 0;
      chk("drain_stall", stall, 1);
      step;
      chk("drain_wait", {stall, ld_done}, 2'b10);
      bus.mem_rvalid = 1;
      bus.mem_rdata = 32'hDEADBEEF;
      step;
      bus.mem_rvalid = 0;
      chk("drain_ready", {ld_ready, ld_done}, 2'b10);
      chk("drain_result", ld_result, last_res);
      // response timeout
      issue(EXE_LW_OP, 32'h6000);
      bus.mem_gnt = 1;
      step;
      bus.mem_gnt = 0;
      n = 0;
      for (int i = 0; i < 100 && !bus_err; i++) begin
         step;
         n++;
      end
      chk("timeout_cycles", n, 64);
      chk("timeout_state", {bus_err, ld_ready, ld_done}, 3'b110);
      step;
      chk("timeout_pulse", bus_err, 0);
      // async reset mid-RESP, then a stale response
      issue(EXE_LW_OP, 32'h7000);
      bus.mem_gnt = 1;
      step;
      bus.mem_gnt = 0;
      rst = 1;
      #1;
      chk("arst_outs", {ld_ready, stall, bus.mem_req, ld_done, bus_err}, 5'b10000);
      chk("arst_addr", bus.mem_addr, 0);
      chk("arst_result", ld_result, 0);
      step;
      rst = 0;
      bus.mem_rvalid = 1;
      bus.mem_rdata = 32'hCAFEBABE;
      step;
      bus.mem_rvalid = 0;
      chk("stale_ignored", {ld_done, ld_ready}, 2'b01);
      chk("stale_result", ld_result, 0);
`ifdef LOAD_MISALIGN_EXC_EN
      issue(EXE_LW_OP, 32'h1002);
      chk("mis_noreq", {bus.mem_req, ld_ready, adel}, 3'b011);
      chk("mis_badvaddr", badvaddr, 32'h00001002);
      step;
      chk("mis_pulse", {adel, ld_done, bus.mem_req}, 3'b000);
`else
      chk("mis_adel_tied", {adel, badvaddr}, 33'h0);
      load("lw_1002", EXE_LW_OP, 32'h1002, 32'hCAFEF00D, 32'hCAFEF00D, 0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
